// File: rtl/reg_file.sv
// 32-entry integer register file: two bypassable read ports, one write port,
// a never-bypassed debug read port and a committed-write counter. x0 reads as zero.
module reg_file #(
    parameter int unsigned N      = 32,
    parameter int unsigned ADDR_W = 5,
    parameter bit          BYPASS = 1'b1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] a1_i,
    input  logic [ADDR_W-1:0] a2_i,
    input  logic [ADDR_W-1:0] a3_i,
    input  logic              we3_i,
    input  logic [N-1:0]      wd3_i,
    output logic [N-1:0]      rd1_o,
    output logic [N-1:0]      rd2_o,
    input  logic [ADDR_W-1:0] dbg_a_i,
    output logic [N-1:0]      dbg_rd_o,
    output logic [15:0]       wr_count_o
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    // x0 has no storage; entry 0 is deliberately absent from the array.
    logic [N-1:0] regs_q [1:Depth-1];
    logic [15:0]  wr_count_q;
    logic [15:0]  wr_count_d;
    logic         wr_en;

    assign wr_en      = we3_i && !reset_i && (a3_i != '0);
    assign wr_count_d = wr_count_q + 16'd1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 1; i < Depth; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else if (wr_en) begin
            regs_q[a3_i] <= wd3_i;
            wr_count_q   <= wr_count_d;
        end
    end

    always_comb begin
        rd1_o    = '0;
        rd2_o    = '0;
        dbg_rd_o = '0;
        if (a1_i != '0) begin
            rd1_o = (BYPASS && wr_en && (a3_i == a1_i)) ? wd3_i : regs_q[a1_i];
        end
        if (a2_i != '0) begin
            rd2_o = (BYPASS && wr_en && (a3_i == a2_i)) ? wd3_i : regs_q[a2_i];
        end
        if (dbg_a_i != '0) begin
            dbg_rd_o = regs_q[dbg_a_i];
        end
    end

    assign wr_count_o = wr_count_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: a forwarding instance and a non-forwarding instance
// share all inputs so the two read behaviours can be compared in the same cycle.
module tb_reg_file;

    logic        clk;
    logic        reset;
    logic [4:0]  a1, a2, a3, dbg_a;
    logic        we3;
    logic [31:0] wd3;
    logic [31:0] b_rd1, b_rd2, b_dbg, n_rd1, n_rd2, n_dbg;
    logic [15:0] b_cnt, n_cnt;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    reg_file #(.N(32), .ADDR_W(5), .BYPASS(1'b1)) u_byp (
        .clk_i(clk), .reset_i(reset), .a1_i(a1), .a2_i(a2), .a3_i(a3), .we3_i(we3),
        .wd3_i(wd3), .rd1_o(b_rd1), .rd2_o(b_rd2), .dbg_a_i(dbg_a), .dbg_rd_o(b_dbg),
        .wr_count_o(b_cnt)
    );

    reg_file #(.N(32), .ADDR_W(5), .BYPASS(1'b0)) u_nob (
        .clk_i(clk), .reset_i(reset), .a1_i(a1), .a2_i(a2), .a3_i(a3), .we3_i(we3),
        .wd3_i(wd3), .rd1_o(n_rd1), .rd2_o(n_rd2), .dbg_a_i(dbg_a), .dbg_rd_o(n_dbg),
        .wr_count_o(n_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are sampled before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        we3 = 1'b1;
        a3  = addr;
        wd3 = data;
        tick();
        we3 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        a1 = 5'd5; a2 = 5'd31; dbg_a = 5'd17;
        #1;
        total_cnt++;
        if (b_rd1 !== 32'h0) $display("FAIL reset_rd1: got %h want %h", b_rd1, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (b_rd2 !== 32'h0) $display("FAIL reset_rd2: got %h want %h", b_rd2, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (b_cnt !== 16'h0) $display("FAIL reset_count: got %h want %h", b_cnt, 16'h0);
        else pass_cnt++;

        write_reg(5'd5, 32'hDEADBEEF);
        dbg_a = 5'd5;
        #1;
        total_cnt++;
        if (b_dbg !== 32'hDEADBEEF) $display("FAIL pre_reset_x5: got %h want %h", b_dbg, 32'hDEADBEEF);
        else pass_cnt++;

        // Reset with a competing write; forwarding must be suppressed while reset is high.
        reset = 1'b1; we3 = 1'b1; a3 = 5'd6; wd3 = 32'h1; a1 = 5'd6;
        #1;
        total_cnt++;
        if (b_rd1 !== 32'h0) $display("FAIL reset_no_bypass: got %h want %h", b_rd1, 32'h0);
        else pass_cnt++;
        tick();
        reset = 1'b0; we3 = 1'b0;
        dbg_a = 5'd5; a1 = 5'd6;
        #1;
        total_cnt++;
        if (b_dbg !== 32'h0) $display("FAIL reset_x5: got %h want %h", b_dbg, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (b_rd1 !== 32'h0) $display("FAIL reset_wins_x6: got %h want %h", b_rd1, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (b_cnt !== 16'h0) $display("FAIL reset_count_after: got %h want %h", b_cnt, 16'h0);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        write_reg(5'd1, 32'h0000_1234);
        write_reg(5'd31, 32'hFFFF_FFFF);
        a1 = 5'd1; a2 = 5'd31;
        #1;
        total_cnt++;
        if (b_rd1 !== 32'h0000_1234) $display("FAIL basic_rd1: got %h want %h", b_rd1, 32'h1234);
        else pass_cnt++;
        total_cnt++;
        if (b_rd2 !== 32'hFFFF_FFFF) $display("FAIL basic_rd2: got %h want %h", b_rd2, 32'hFFFFFFFF);
        else pass_cnt++;
        total_cnt++;
        if (b_cnt !== 16'd2) $display("FAIL basic_count: got %0d want %0d", b_cnt, 2);
        else pass_cnt++;
    endtask

    task automatic test_x0();
        we3 = 1'b1; a3 = 5'd0; wd3 = 32'hA5A5A5A5; a1 = 5'd0; dbg_a = 5'd0;
        #1;
        total_cnt++;
        if (b_rd1 !== 32'h0) $display("FAIL x0_no_bypass: got %h want %h", b_rd1, 32'h0);
        else pass_cnt++;
        tick();
        we3 = 1'b0;
        #1;
        total_cnt++;
        if (b_rd1 !== 32'h0) $display("FAIL x0_rd1: got %h want %h", b_rd1, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (b_dbg !== 32'h0) $display("FAIL x0_dbg: got %h want %h", b_dbg, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (b_cnt !== 16'd2) $display("FAIL x0_count: got %0d want %0d", b_cnt, 2);
        else pass_cnt++;

        // Unknown enable and address must leave x0 reading zero.
        we3 = 1'bx; a3 = 5'bx; wd3 = 32'h5A5A5A5A;
        tick();
        we3 = 1'b0; a3 = 5'd0;
        #1;
        total_cnt++;
        if (b_rd1 !== 32'h0) $display("FAIL x0_unknown: got %h want %h", b_rd1, 32'h0);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        write_reg(5'd7, 32'h11);
        we3 = 1'b1; a3 = 5'd7; wd3 = 32'h22; a1 = 5'd7; a2 = 5'd7; dbg_a = 5'd7;
        #1;
        total_cnt++;
        if (b_rd1 !== 32'h22) $display("FAIL byp_rd1: got %h want %h", b_rd1, 32'h22);
        else pass_cnt++;
        total_cnt++;
        if (b_rd2 !== 32'h22) $display("FAIL byp_rd2: got %h want %h", b_rd2, 32'h22);
        else pass_cnt++;
        total_cnt++;
        if (b_dbg !== 32'h11) $display("FAIL byp_dbg_pre: got %h want %h", b_dbg, 32'h11);
        else pass_cnt++;
        total_cnt++;
        if (n_rd1 !== 32'h11) $display("FAIL nob_rd1_pre: got %h want %h", n_rd1, 32'h11);
        else pass_cnt++;
        total_cnt++;
        if (n_rd2 !== 32'h11) $display("FAIL nob_rd2_pre: got %h want %h", n_rd2, 32'h11);
        else pass_cnt++;
        tick();
        we3 = 1'b0;
        #1;
        total_cnt++;
        if (b_dbg !== 32'h22) $display("FAIL byp_dbg_post: got %h want %h", b_dbg, 32'h22);
        else pass_cnt++;
        total_cnt++;
        if (n_rd1 !== 32'h22) $display("FAIL nob_rd1_post: got %h want %h", n_rd1, 32'h22);
        else pass_cnt++;
        total_cnt++;
        if (n_rd2 !== 32'h22) $display("FAIL nob_rd2_post: got %h want %h", n_rd2, 32'h22);
        else pass_cnt++;
        total_cnt++;
        if (b_cnt !== 16'd4) $display("FAIL byp_count: got %0d want %0d", b_cnt, 4);
        else pass_cnt++;
    endtask

    task automatic test_sweep();
        logic [31:0] exp;
        int unsigned errs;
        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), 32'(i) * 32'h01010101);
        end
        errs = 0;
        for (int i = 1; i < 32; i++) begin
            exp = 32'(i) * 32'h01010101;
            a1 = 5'(i); a2 = 5'(32 - i); dbg_a = 5'(i);
            #1;
            total_cnt++;
            if (b_rd1 !== exp || b_dbg !== exp || n_rd1 !== exp) begin
                $display("FAIL sweep_x%0d: got %h/%h/%h want %h", i, b_rd1, b_dbg, n_rd1, exp);
            end else begin
                pass_cnt++;
            end
            total_cnt++;
            if (b_rd2 !== 32'(32 - i) * 32'h01010101) begin
                $display("FAIL sweep_rd2_x%0d: got %h want %h", 32 - i, b_rd2,
                         32'(32 - i) * 32'h01010101);
            end else begin
                pass_cnt++;
            end
        end
        total_cnt++;
        if (b_cnt !== 16'd35) $display("FAIL sweep_count: got %0d want %0d", b_cnt, 35);
        else pass_cnt++;

        write_reg(5'd3, 32'hAAAA_0001);
        write_reg(5'd3, 32'hBBBB_0002);
        a1 = 5'd3; a2 = 5'd3;
        #1;
        total_cnt++;
        if (b_rd1 !== 32'hBBBB_0002) $display("FAIL last_wins: got %h want %h", b_rd1, 32'hBBBB0002);
        else pass_cnt++;
        total_cnt++;
        if (b_rd2 !== b_rd1) $display("FAIL same_addr: got %h want %h", b_rd2, 32'hBBBB0002);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        we3 = 1'b1; a3 = 5'd9; wd3 = 32'h9;
        repeat (65535) tick();
        total_cnt++;
        if (b_cnt !== 16'hFFFF) $display("FAIL wrap_max: got %h want %h", b_cnt, 16'hFFFF);
        else pass_cnt++;
        tick();
        we3 = 1'b0;
        #1;
        total_cnt++;
        if (b_cnt !== 16'h0) $display("FAIL wrap_zero: got %h want %h", b_cnt, 16'h0);
        else pass_cnt++;
        total_cnt++;
        if (n_cnt !== 16'h0) $display("FAIL wrap_zero_nob: got %h want %h", n_cnt, 16'h0);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; we3 = 1'b0; wd3 = '0;
        a1 = '0; a2 = '0; a3 = '0; dbg_a = '0;
        tick();
        test_reset();
        test_basic();
        test_x0();
        test_bypass();
        test_sweep();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
